// File: rtl/oam_dma_ctrl_if.sv
// ---------------------------------------------------------------------------
// oam_dma_ctrl_if
// Groups the CPU-side handshake and the DMA bus-master signals of the OAM DMA
// sequencer.
//   cpu_ce      : one-clk strobe at the end of every CPU cycle
//   start/page  : CPU write to $4014 and the source page written with it
//   cpu_rw      : r/w of the CPU cycle in progress (1 = read)
//   bus_data_i  : CPU bus read data, valid at cpu_ce
//   halt/busy   : CPU stall request / DMA owns or is requesting the bus
//   bus_*       : DMA address, read/write strobes and write data
//   done        : one-clk pulse when a transfer finishes
// modport master: the DMA controller.  modport slave: the CPU/bus side.
// ---------------------------------------------------------------------------
interface oam_dma_ctrl_if;
  logic        cpu_ce;
  logic        start;
  logic [7:0]  page;
  logic        cpu_rw;
  logic [7:0]  bus_data_i;
  logic        halt;
  logic        busy;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_data_o;
  logic        done;

  modport master (
    input  cpu_ce, start, page, cpu_rw, bus_data_i,
    output halt, busy, bus_addr, bus_rd, bus_wr, bus_data_o, done
  );

  modport slave (
    output cpu_ce, start, page, cpu_rw, bus_data_i,
    input  halt, busy, bus_addr, bus_rd, bus_wr, bus_data_o, done
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// oam_dma_ctrl
// OAM DMA sequencer. A CPU write to $4014 (start/page) arms a transfer; the
// controller halts the CPU, then copies XFER_LEN bytes from {page,idx} to
// OAMDATA_ADDR using alternating get (read) / put (write) CPU cycles. All
// sequencing advances on cpu_ce only; the DONE state lasts a single clk.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   dma      : oam_dma_ctrl_if.master (CPU handshake + DMA bus master)
// Outputs are a pure decode of registered state, so they move one clk after
// the cpu_ce that causes a transition.
// ---------------------------------------------------------------------------
module oam_dma_ctrl #(
  parameter logic [15:0] OAMDATA_ADDR = 16'h2004,
  parameter int          XFER_LEN     = 256
) (
  input  logic           clk,
  input  logic           rst,
  oam_dma_ctrl_if.master dma
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE,
    DONE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t      state_reg;
  logic        pend_reg;
  logic        p_reg;      // CPU cycle parity: 0 = get, 1 = put
  logic [7:0]  page_reg;
  logic [7:0]  idx_reg;
  logic [7:0]  data_reg;

  logic        halt_d;
  logic        busy_d;
  logic [15:0] addr_d;
  logic        rd_d;
  logic        wr_d;
  logic [7:0]  dout_d;
  logic        done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pend_reg  <= 1'b0;
      p_reg     <= 1'b0;
      page_reg  <= 8'h00;
      idx_reg   <= 8'h00;
      data_reg  <= 8'h00;
    end else begin
      // A start while a transfer is armed or running is dropped.
      if (dma.start && !busy_d && !pend_reg) begin
        pend_reg <= 1'b1;
        page_reg <= dma.page;
      end

      if (dma.cpu_ce) begin
        p_reg <= ~p_reg;
      end

      case (state_reg)
        IDLE: begin
          // pend is sampled from the register, so a start coinciding with
          // cpu_ce only arms; the halt begins at the following cpu_ce.
          if (dma.cpu_ce && pend_reg) begin
            state_reg <= HALT;
            pend_reg  <= 1'b0;
          end
        end
        HALT: begin
          // A CPU write cycle cannot be stalled, so keep requesting. Once a
          // read cycle is stalled, the next cycle is a get when the current
          // parity is a put (p_reg=1).
          if (dma.cpu_ce && dma.cpu_rw) begin
            state_reg <= p_reg ? READ : ALIGN;
          end
        end
        ALIGN: begin
          if (dma.cpu_ce) begin
            state_reg <= READ;
          end
        end
        READ: begin
          if (dma.cpu_ce) begin
            data_reg  <= dma.bus_data_i;
            state_reg <= WRITE;
          end
        end
        WRITE: begin
          if (dma.cpu_ce) begin
            if (idx_reg == LAST_IDX) begin
              idx_reg   <= 8'h00;
              state_reg <= DONE;
            end else begin
              idx_reg   <= idx_reg + 8'h01;
              state_reg <= READ;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    halt_d = 1'b0;
    busy_d = 1'b0;
    addr_d = 16'h0000;
    rd_d   = 1'b0;
    wr_d   = 1'b0;
    dout_d = 8'h00;
    done_d = 1'b0;
    case (state_reg)
      HALT, ALIGN: begin
        halt_d = 1'b1;
        busy_d = 1'b1;
      end
      READ: begin
        halt_d = 1'b1;
        busy_d = 1'b1;
        addr_d = {page_reg, idx_reg};
        rd_d   = 1'b1;
      end
      WRITE: begin
        halt_d = 1'b1;
        busy_d = 1'b1;
        addr_d = OAMDATA_ADDR;
        wr_d   = 1'b1;
        dout_d = data_reg;
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign dma.halt       = halt_d;
  assign dma.busy       = busy_d;
  assign dma.bus_addr   = addr_d;
  assign dma.bus_rd     = rd_d;
  assign dma.bus_wr     = wr_d;
  assign dma.bus_data_o = dout_d;
  assign dma.done       = done_d;

endmodule
